// File: rtl/apb_req_arbiter_pkg.sv
// Shared types for the APB request arbiter: FSM state encoding, default bus
// widths and the latched command record.
// Optional build macro: APB_ARB_TIMEOUT_EN (ACCESS-phase timeout abort).
package apb_arb_pkg;

  // Default APB widths; also the widths of the latched command record
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_m_st_t;

  // Command captured from the granted requester at grant time
  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Bundle of the requester-side handshake and the APB master bus.
// The master modport is the arbiter's view; the slave modport is the view of
// whatever sits around it (requesters plus the APB slave register block).
interface apb_req_arbiter_if
  import apb_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // Requester side
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  // APB master port
  logic                   m_psel;
  logic                   m_penable;
  logic                   m_pwrite;
  logic [ADDR_W-1:0]      m_paddr;
  logic [DATA_W-1:0]      m_pwdata;
  logic                   m_pready;
  logic                   m_pslverr;
  logic [DATA_W-1:0]      m_prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  m_pready, m_pslverr, m_prdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output m_pready, m_pslverr, m_prdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata
  );

endinterface

// File: rtl/apb_req_arbiter_rr.sv
// Combinational round-robin picker. The search starts at ptr_i and wraps
// upward; the first set request bit wins. The pointer register lives in the
// parent so it only advances on an actual grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]                          req_i,
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr_i,
  output logic [NREQ-1:0]                          gnt_o,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] gnt_idx_o
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W:0] NREQ_X = (IDX_W + 1)'(NREQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Walk the requesters from the pointer position, wrapping modulo NREQ
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (sum >= NREQ_X) begin
        sum = sum - NREQ_X;
      end
      idx = sum[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB slave between NREQ local requesters. A round-robin grant is
// taken in IDLE, the winner's command is latched, and a full SETUP/ACCESS
// transfer is run; the completion (read data, error) is returned to the
// granted requester one cycle after the slave's pready is sampled.
// Optional build macro: APB_ARB_TIMEOUT_EN aborts a transfer whose pready
// has not arrived after TIMEOUT ACCESS cycles. Without it ACCESS waits
// for pready indefinitely.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_req_arbiter_if.master  bus
);

  localparam int               IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  // Reject configurations the latched command record or pointer cannot hold
  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 ||
      ADDR_W > DEF_ADDR_W || DATA_W > DEF_DATA_W) begin : g_cfg_err
    $error("apb_req_arbiter: unsupported parameter set");
  end

  apb_m_st_t         state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  apb_cmd_t          cmd_q, cmd_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]   gnt;
  logic [IDX_W-1:0]  gnt_idx;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int              CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req_i     (bus.req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // State, pointer, latched command and response registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      cmd_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      cmd_q       <= cmd_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Next-state logic: grant in IDLE, one SETUP cycle, wait in ACCESS
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    cmd_d       = cmd_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          gidx_d      = gnt_idx;
          cmd_d.write = bus.req_write[gnt_idx];
          cmd_d.addr  = DEF_ADDR_W'(bus.req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W]);
          cmd_d.wdata = DEF_DATA_W'(bus.req_wdata[int'(gnt_idx)*DATA_W +: DATA_W]);
          req_ready_d = gnt;
          ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ACCESS: begin
        if (bus.m_pready) begin
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_rdata_d         = cmd_q.write ? '0 : bus.m_prdata;
          rsp_err_d           = bus.m_pslverr;
          state_d             = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_valid_d[gidx_q] = 1'b1;
          rsp_rdata_d         = '0;
          rsp_err_d           = 1'b1;
          state_d             = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.m_psel    = (state_q != IDLE);
  assign bus.m_penable = (state_q == ACCESS);
  assign bus.m_pwrite  = cmd_q.write;
  assign bus.m_paddr   = cmd_q.addr[ADDR_W-1:0];
  assign bus.m_pwdata  = cmd_q.wdata[DATA_W-1:0];
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter with two requesters and a small APB
// slave model (32-word memory, programmable wait states, error and hang).
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic pclk = 1'b0;
  logic presetn;

  int checks = 0;
  int errors = 0;

  rsp_t rspQ[$];
  int   grantQ[$];

  int issueCnt[2]  = '{0, 0};
  int acceptCnt[2] = '{0, 0};

  logic [31:0] mem [32] = '{default: 32'h0};
  int   waitCnt    = 0;
  int   slaveWaits = 0;
  bit   slaveHang  = 1'b0;
  bit   slaveErr   = 1'b0;

  apb_req_arbiter_if #(.NREQ(2), .ADDR_W(32), .DATA_W(32)) bus ();

  apb_req_arbiter #(
    .NREQ    (2),
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  // A request stays pending until its accept pulse has been seen
  assign bus.req_valid = {issueCnt[1] != acceptCnt[1], issueCnt[0] != acceptCnt[0]};

  // APB slave model
  assign bus.m_pready  = bus.m_psel && bus.m_penable && !slaveHang && (waitCnt >= slaveWaits);
  assign bus.m_pslverr = slaveErr;
  assign bus.m_prdata  = mem[bus.m_paddr[6:2]];

  always @(posedge pclk) begin
    if (bus.m_psel && bus.m_penable && !bus.m_pready) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
    if (bus.m_psel && bus.m_penable && bus.m_pready && bus.m_pwrite)
      mem[bus.m_paddr[6:2]] <= bus.m_pwdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expectTxn(input int g, input logic [31:0] rdata, input logic err, input bit hasRsp);
    rsp_t r;
    grantQ.push_back(g);
    if (hasRsp) begin
      r.idx = g; r.rdata = rdata; r.err = err;
      rspQ.push_back(r);
    end
  endtask

  task automatic applyStimulus(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_write[i]         = wr;
    bus.req_addr[i*32 +: 32]  = addr;
    bus.req_wdata[i*32 +: 32] = wdata;
    issueCnt[i]++;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while ((rspQ.size() != 0 || grantQ.size() != 0) && n < maxCycles) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("drain timeout", 32'(rspQ.size() + grantQ.size()), 32'd0);
    @(negedge pclk);
  endtask

  // Requester side: drop a request in the cycle after its accept pulse
  initial begin
    logic [1:0] seen;
    forever begin
      @(posedge pclk);
      seen = bus.req_ready;
      #1;
      for (int i = 0; i < 2; i++) if (seen[i]) acceptCnt[i]++;
    end
  end

  // Monitor: compare every accept and completion pulse against the queues
  initial begin
    int   g;
    rsp_t r;
    forever begin
      @(negedge pclk);
      if (presetn === 1'b1) begin
        if (|bus.req_ready) begin
          if (grantQ.size() == 0) checkOutput("unexpected req_ready", 32'(bus.req_ready), 32'd0);
          else begin
            g = grantQ.pop_front();
            checkOutput("req_ready grant", 32'(bus.req_ready), 32'(1 << g));
          end
        end
        if (|bus.rsp_valid) begin
          checkOutput("psel idle at rsp", 32'(bus.m_psel), 32'd0);
          if (rspQ.size() == 0) checkOutput("unexpected rsp_valid", 32'(bus.rsp_valid), 32'd0);
          else begin
            r = rspQ.pop_front();
            checkOutput("rsp_valid bit", 32'(bus.rsp_valid), 32'(1 << r.idx));
            checkOutput("rsp_rdata", bus.rsp_rdata, r.rdata);
            checkOutput("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Directed stimulus
  initial begin
    presetn       = 1'b0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(negedge pclk);
    checkOutput("reset psel", 32'(bus.m_psel), 32'd0);
    checkOutput("reset penable", 32'(bus.m_penable), 32'd0);
    checkOutput("reset req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset paddr", bus.m_paddr, 32'd0);
    presetn = 1'b1;
    @(negedge pclk);

    // Write from requester 0, zero-wait slave, with cycle-exact checks
    $display("[TB] write req0");
    expectTxn(0, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 32'h04, 32'h20250101);
    @(posedge pclk); #1;
    checkOutput("setup psel", 32'(bus.m_psel), 32'd1);
    checkOutput("setup penable", 32'(bus.m_penable), 32'd0);
    checkOutput("setup paddr", bus.m_paddr, 32'h04);
    checkOutput("setup pwdata", bus.m_pwdata, 32'h20250101);
    @(posedge pclk); #1;
    checkOutput("access psel", 32'(bus.m_psel), 32'd1);
    checkOutput("access penable", 32'(bus.m_penable), 32'd1);
    @(posedge pclk); #1;
    checkOutput("latency rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("latency psel", 32'(bus.m_psel), 32'd0);
    waitIdle(20);

    // Read-back from requester 1 through a one-wait-state slave
    $display("[TB] read-back req1");
    slaveWaits = 1;
    expectTxn(1, 32'h20250101, 1'b0, 1'b1);
    applyStimulus(1, 1'b0, 32'h04, 32'h0);
    waitIdle(20);

    // Contention: both requesters together, twice
    $display("[TB] contention");
    slaveWaits = 0;
    for (int rep = 0; rep < 2; rep++) begin
      expectTxn(0, 32'h0, 1'b0, 1'b1);
      expectTxn(1, 32'h0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 32'h08, 32'hA0A0_0000 + 32'(rep));
      applyStimulus(1, 1'b1, 32'h0C, 32'hB0B0_0000 + 32'(rep));
      waitIdle(40);
    end
    checkOutput("contention mem 0x08", mem[2], 32'hA0A0_0001);
    checkOutput("contention mem 0x0C", mem[3], 32'hB0B0_0001);

    // Slave error on requester 1
    $display("[TB] slave error");
    slaveErr   = 1'b1;
    slaveWaits = 2;
    expectTxn(1, 32'h0, 1'b1, 1'b1);
    applyStimulus(1, 1'b1, 32'h40, 32'hDEAD_0040);
    waitIdle(20);
    slaveErr   = 1'b0;
    slaveWaits = 0;

    // Slave that never answers
    $display("[TB] hung slave");
    slaveHang = 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
    expectTxn(0, 32'h0, 1'b1, 1'b1);
    applyStimulus(0, 1'b0, 32'h04, 32'h0);
    waitIdle(40);
    expectTxn(0, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h04, 32'h0);
    repeat (5) @(negedge pclk);
`else
    expectTxn(0, 32'h0, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 32'h04, 32'h0);
    repeat (100) @(negedge pclk);
`endif
    checkOutput("hang psel", 32'(bus.m_psel), 32'd1);
    checkOutput("hang penable", 32'(bus.m_penable), 32'd1);
    checkOutput("hang grant consumed", 32'(grantQ.size()), 32'd0);

    // Asynchronous reset in the middle of ACCESS
    $display("[TB] reset mid-transfer");
    @(posedge pclk); #3;
    presetn = 1'b0;
    #1;
    checkOutput("async psel", 32'(bus.m_psel), 32'd0);
    checkOutput("async penable", 32'(bus.m_penable), 32'd0);
    checkOutput("async req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("async rsp_valid", 32'(bus.rsp_valid), 32'd0);
    slaveHang = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // Pointer back at 0: requester 0 wins first
    expectTxn(0, 32'h20250101, 1'b0, 1'b1);
    expectTxn(1, 32'h0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 32'h04, 32'h0);
    applyStimulus(1, 1'b1, 32'h10, 32'h5555_AAAA);
    waitIdle(40);
    checkOutput("post-reset mem 0x10", mem[4], 32'h5555_AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
